// File: rtl/counter_pkg.sv
// Shared constants for the programmable up/down counter family.
package counter_pkg;

    // Count direction as seen on the 'up' input.
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Boundary behaviour as seen on the 'sat' input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_mod_counter_step.sv
// Next-value and boundary detection for one enabled counter step.
// Purely combinational: the caller decides whether the step is taken.
module updown_mod_counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt_val,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    // Compute the value after one step in the current direction and mode.
    // The +1 only happens below limit and the -1 only above zero, so the
    // WIDTH-bit arithmetic can never roll over on its own.
    always_comb begin
        nxt_val  = cur_val;
        boundary = 1'b0;
        if (up == DIR_UP) begin
            if (cur_val < limit) begin
                nxt_val = cur_val + ONE;
            end else begin
                boundary = 1'b1;
                if (sat == MODE_SAT) begin
                    // Holds at limit, or pulls an above-limit value back to it.
                    nxt_val = limit;
                end else begin
                    nxt_val = ZERO;
                end
            end
        end else begin
            if (cur_val > limit) begin
                // Re-entering the range from above is not a boundary.
                nxt_val = limit;
            end else if (cur_val != ZERO) begin
                nxt_val = cur_val - ONE;
            end else begin
                boundary = 1'b1;
                if (sat == MODE_SAT) begin
                    nxt_val = ZERO;
                end else begin
                    nxt_val = limit;
                end
            end
        end
    end

endmodule : updown_mod_counter_step

// File: rtl/updown_mod_counter.sv
// Programmable-modulus up/down counter with wrap/saturate modes,
// a one-cycle boundary pulse and a sticky boundary flag.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] step_val_s;
    logic             step_bnd_s;

    updown_mod_counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur_val  (out_q),
        .up       (up),
        .limit    (limit),
        .sat      (sat),
        .nxt_val  (step_val_s),
        .boundary (step_bnd_s)
    );

    // Next-state selection: load beats count enable, otherwise hold.
    // A boundary step sets ovf even when clr_ovf is asserted alongside it.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q & ~clr_ovf;
        if (load) begin
            out_d = data;
        end else if (en) begin
            out_d = step_val_s;
            if (step_bnd_s) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
            end else begin
                wrap_d = 1'b0;
            end
        end else begin
            out_d = out_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Terminal count is decoded directly from the current count, direction and limit.
    always_comb begin
        if (up == DIR_UP) begin
            tc = (out_q >= limit);
        end else begin
            tc = (out_q == {WIDTH{1'b0}});
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=8, RESET_VAL=5):
// directed scenarios followed by random traffic against a reference model.
module tb_updown_mod_counter;

    localparam int W    = 8;
    localparam int RVAL = 5;

    logic         clk;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] data;
    logic         up;
    logic [W-1:0] limit;
    logic         sat;
    logic         clr_ovf;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    logic         ovf;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state, kept as plain integers.
    int m_out  = 0;
    int m_wrap = 0;
    int m_ovf  = 0;

    updown_mod_counter #(
        .WIDTH     (W),
        .RESET_VAL (8'd5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .data    (data),
        .up      (up),
        .limit   (limit),
        .sat     (sat),
        .clr_ovf (clr_ovf),
        .out     (out),
        .tc      (tc),
        .wrap    (wrap),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks_total = checks_total + 1;
        assert (obs === exp) checks_passed = checks_passed + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Apply the counter rules to the model for the inputs currently driven.
    function automatic void model_edge();
        int l;
        int nxt;
        bit bnd;
        l   = int'(limit);
        nxt = m_out;
        bnd = 1'b0;
        if (!reset) begin
            m_out = RVAL; m_wrap = 0; m_ovf = 0;
            return;
        end
        if (load) begin
            m_out  = int'(data);
            m_wrap = 0;
            if (clr_ovf) m_ovf = 0;
            return;
        end
        if (en) begin
            if (up) begin
                if (m_out < l) nxt = m_out + 1;
                else begin bnd = 1'b1; nxt = sat ? l : 0; end
            end else begin
                if (m_out > l)      nxt = l;
                else if (m_out > 0) nxt = m_out - 1;
                else begin bnd = 1'b1; nxt = sat ? 0 : l; end
            end
        end
        m_out  = nxt;
        m_wrap = bnd ? 1 : 0;
        if (bnd)          m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endfunction

    // One clock: advance the model, let the edge pass, compare all outputs.
    task automatic tick(input string tag);
        int m_tc;
        model_edge();
        @(posedge clk);
        #1;
        m_tc = up ? ((m_out >= int'(limit)) ? 1 : 0) : ((m_out == 0) ? 1 : 0);
        check({tag, ".out"},  int'(out),  m_out);
        check({tag, ".wrap"}, int'(wrap), m_wrap);
        check({tag, ".ovf"},  int'(ovf),  m_ovf);
        check({tag, ".tc"},   int'(tc),   m_tc);
    endtask

    initial begin
        int exp_seq_up [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int exp_dn     [4]  = '{1, 0, 0, 0};
        int exp_dn_wr  [4]  = '{0, 0, 1, 1};

        // Reset wins over load and enable.
        reset = 1'b0; load = 1'b1; data = 8'hAA; en = 1'b1; up = 1'b1;
        limit = 8'd9; sat = 1'b0; clr_ovf = 1'b0;
        tick("rst");
        check("rst_out_const", int'(out), 5);
        check("rst_wrap_const", int'(wrap), 0);
        check("rst_ovf_const", int'(ovf), 0);

        // Load after reset release.
        reset = 1'b1; load = 1'b1; data = 8'h3C; en = 1'b0;
        tick("load");
        check("load_const", int'(out), 8'h3C);

        // Up count with wrap over 0..9.
        data = 8'd0;
        tick("load0");
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; limit = 8'd9;
        for (int i = 0; i < 10; i++) begin
            tick("upwrap");
            check("upwrap_seq", int'(out), exp_seq_up[i]);
            check("upwrap_pulse", int'(wrap), (i == 9) ? 1 : 0);
            if (i == 8) check("upwrap_tc9", int'(tc), 1);
        end
        tick("upwrap_after");
        check("upwrap_ovf_sticky", int'(ovf), 1);
        check("upwrap_after_wrap", int'(wrap), 0);

        // Down count saturating at zero.
        sat = 1'b1; up = 1'b0; load = 1'b1; en = 1'b0; data = 8'd2;
        tick("dnload");
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("dnsat");
            check("dnsat_seq", int'(out), exp_dn[i]);
            check("dnsat_pulse", int'(wrap), exp_dn_wr[i]);
        end
        check("dnsat_tc0", int'(tc), 1);

        // Count value above limit.
        limit = 8'd50; sat = 1'b0; load = 1'b1; en = 1'b0; data = 8'd200; up = 1'b1;
        tick("above_load");
        load = 1'b0; en = 1'b1;
        tick("above_up");
        check("above_up_out", int'(out), 0);
        check("above_up_wrap", int'(wrap), 1);
        load = 1'b1; en = 1'b0;
        tick("above_load2");
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick("above_dn");
        check("above_dn_out", int'(out), 50);
        check("above_dn_wrap", int'(wrap), 0);

        // Set/clear race on the sticky flag.
        en = 1'b0; clr_ovf = 1'b1;
        tick("clr_first");
        check("clr_first_ovf", int'(ovf), 0);
        clr_ovf = 1'b0; limit = 8'd9; up = 1'b1; load = 1'b1; data = 8'd9;
        tick("race_load");
        load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
        tick("race");
        check("race_set_wins", int'(ovf), 1);
        en = 1'b0;
        tick("race_clr");
        check("race_clear", int'(ovf), 0);
        clr_ovf = 1'b0;

        // Zero limit: every step is a boundary; then enable low holds.
        limit = 8'd0; load = 1'b1; data = 8'd0;
        tick("lim0_load");
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up = (i == 1) ? 1'b0 : 1'b1;
            tick("lim0");
            check("lim0_out", int'(out), 0);
            check("lim0_wrap", int'(wrap), 1);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up = ~up;
            tick("hold");
            check("hold_wrap", int'(wrap), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 49) != 0);
            load    = ($urandom_range(0, 9) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up      = $urandom_range(0, 1) == 1;
            sat     = $urandom_range(0, 1) == 1;
            clr_ovf = ($urandom_range(0, 7) == 0);
            data    = W'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) limit = W'($urandom_range(0, 255));
            else                           limit = W'($urandom_range(0, 12));
            tick("rand");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised, programmable-modulus up/down counter: the next-generation general counter for datapath and timing control. It adds the following over the fixed 8-bit load/increment counter:
- configurable width and reset value;
- count direction;
- runtime modulus limit;
- wrap or saturate mode;
- a count enable;
- boundary event and sticky overflow flags.

It is used stand-alone or as the base for timers and address generators.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- RESET_VAL, 0, value of out after reset (must be ≤ 2^WIDTH−1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low
- en  in  1  count enable; one step per cycle while high
- load  in  1  parallel load of data
- data  in  WIDTH  load value
- up  in  1  direction: 1 = increment, 0 = decrement
- limit  in  WIDTH  terminal value; counting range is 0..limit
- sat  in  1  1 = saturate at boundary, 0 = wrap
- clr_ovf  in  1  clears sticky overflow flag
- out  out  WIDTH  count value (registered)
- tc  out  1  terminal-count indicator (combinational)
- wrap  out  1  one-cycle boundary event pulse (registered)
- ovf  out  1  sticky boundary flag (registered)

## Operation
- Priority per edge is reset > load > en > hold.
- Reset (reset=0): out=RESET_VAL, wrap=0, ovf=0. This holds regardless of load, en or clr_ovf, and aborts any operation in progress.
- Load (load=1):
  - out=data, even if data > limit.
  - wrap=0; ovf unchanged except by clr_ovf.
- Up step (en=1, up=1):
  - out < limit: out+1.
  - out ≥ limit is a boundary. With sat=0, out=0; with sat=1, out holds if out==limit, and out=limit if out > limit.
- Down step (en=1, up=0):
  - 0 < out ≤ limit: out−1.
  - out > limit: out=limit. This is not a boundary.
  - out==0 is a boundary. With sat=0, out=limit; with sat=1, out holds at 0.
- Boundary step: wrap=1 for exactly the following cycle, and ovf is set. This applies in both sat modes.
- Every non-boundary cycle (including hold and load) has wrap=0.
- Arithmetic is unsigned WIDTH-bit. No intermediate overflow is possible, because the ±1 is only applied away from 0 and 2^WIDTH−1 boundaries.
- limit=0:
  - Every enabled step is a boundary.
  - out stays 0, or goes to 0 via the out>limit rules.
- ovf is cleared by clr_ovf=1. If a boundary step and clr_ovf occur in the same cycle, ovf=1 (set wins).
- tc behaviour:
  - up=1: tc = (out ≥ limit).
  - up=0: tc = (out == 0).
  - tc is purely combinational from out, up and limit. Its reset value follows from out=RESET_VAL.
- limit, up and sat may change on any cycle and take effect on the same edge.

## Timing
- Load and count latency: 1 cycle (value visible on out after the edge).
- wrap asserts in the same cycle out shows the post-boundary value and deasserts the next cycle unless another boundary step occurs.
- With continuous en and sat=0, wrap pulses every limit+1 cycles.
- ovf is visible 1 cycle after the boundary step. A clr_ovf clear is visible 1 cycle after the clr_ovf cycle.
- tc has no register delay; it is stable only after out, up and limit are stable.

## Structure
- Shared package (counter_pkg):
  - direction constants DIR_UP/DIR_DOWN;
  - mode constants MODE_WRAP/MODE_SAT.
- One natural sub-module: updown_mod_counter_step.
  - Purely combinational.
  - Inputs: out, up, limit, sat.
  - Outputs: next value and boundary flag.
- The top holds the out, wrap and ovf registers and the priority logic.

## Test plan
- Reset/load priority:
  - WIDTH=8, RESET_VAL=5. Assert reset=0 with load=1, data=8'hAA, en=1: out=5, wrap=0, ovf=0.
  - Release reset, then load=1, data=8'h3C: out=8'h3C next cycle.
- Up wrap:
  - limit=9, sat=0, up=1, en=1 from out=0: out runs 0..9,0.
  - wrap=1 only in the cycle out returns to 0; ovf=1 thereafter; tc=1 while out=9.
- Down saturate:
  - limit=9, sat=1, up=0, load data=2, then en=1: out 2,1,0,0,0.
  - wrap=1 in each cycle after a step taken at 0; tc=1 at 0.
- Out above limit:
  - Load 200 with limit=50.
  - up=1, sat=0: next en step gives out=0 with wrap=1.
  - Repeat with up=0: out=50 with wrap=0.
- ovf set/clear race:
  - At a boundary step, assert clr_ovf simultaneously: ovf=1.
  - Next cycle clr_ovf=1 with no boundary: ovf=0.
- limit=0 and en=0:
  - limit=0, en=1: out stays 0 and wrap is high every cycle.
  - en=0 with up toggling: out holds, wrap=0.
